// File: rtl/sync_cnt_pkg.sv
// Shared constants for the sync counter/decode stage: the default widths, the
// terminal values, and the equality-decode values the sync controller watches for.
package sync_cnt_pkg;

  localparam int CW_DEF   = 10;
  localparam int PW_DEF   = 8;
  localparam int CMAX_DEF = 1023;
  localparam int PMAX_DEF = 255;

  // Main line/sample counter decode points
  localparam int CNT10  = 10;
  localparam int CNT13  = 13;
  localparam int CNT21  = 21;
  localparam int CNT44  = 44;
  localparam int CNT45  = 45;
  localparam int CNT261 = 261;
  localparam int CNT272 = 272;
  localparam int CNT283 = 283;
  localparam int CNT284 = 284;
  localparam int CNT509 = 509;
  localparam int CNT511 = 511;
  localparam int CNT567 = 567;
  localparam int CNT591 = 591;

  // Pixel counter decode points
  localparam int PCNT6   = 6;
  localparam int PCNT12  = 12;
  localparam int PCNT17  = 17;
  localparam int PCNT27  = 27;
  localparam int PCNT241 = 241;

  localparam int N_CDEC = 13;
  localparam int N_PDEC = 5;

  // Bit i of the decode vectors in the top level corresponds to entry i here
  localparam int CDEC_VAL [N_CDEC] = '{CNT10, CNT13, CNT21, CNT44, CNT45, CNT261,
                                       CNT272, CNT283, CNT284, CNT509, CNT511,
                                       CNT567, CNT591};
  localparam int PDEC_VAL [N_PDEC] = '{PCNT6, PCNT12, PCNT17, PCNT27, PCNT241};

  localparam int CDEC_MAX = CNT591;
  localparam int PDEC_MAX = PCNT241;

  // Minimum number of bits needed to represent a non-negative value
  function automatic int bits_for(input int v);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((v >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_cnt_decode_if.sv
// Bundle between the sync controller (master) and the counter/decode stage
// (slave): control strobes one way, counter values and decodes the other.
interface sync_cnt_decode_if
  import sync_cnt_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int PW = PW_DEF
) ();

  logic          csm;
  logic          cclr;
  logic          pc;
  logic          pclr;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] pcnt_q;
  logic cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272;
  logic cnt283, cnt284, cnt509, cnt511, cnt567, cnt591;
  logic pcnt6, pcnt12, pcnt17, pcnt27, pcnt241;

  modport master (
    output csm, cclr, pc, pclr,
    input  cnt_q, pcnt_q,
    input  cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272,
    input  cnt283, cnt284, cnt509, cnt511, cnt567, cnt591,
    input  pcnt6, pcnt12, pcnt17, pcnt27, pcnt241
  );

  modport slave (
    input  csm, cclr, pc, pclr,
    output cnt_q, pcnt_q,
    output cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272,
    output cnt283, cnt284, cnt509, cnt511, cnt567, cnt591,
    output pcnt6, pcnt12, pcnt17, pcnt27, pcnt241
  );

endinterface

// File: rtl/sync_counter.sv
// Wrapping up-counter with synchronous active-low reset and a clear that
// takes priority over increment. Wraps to zero after the terminal value.
module sync_counter #(
  parameter int W    = 10,
  parameter int TMAX = 1023
) (
  input  logic         CK,
  input  logic         RN,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] TERM = W'(TMAX);
  localparam logic [W-1:0] ONE  = W'(1);

  // Reset, then clear, then increment-with-wrap, otherwise hold
  always_ff @(posedge CK) begin
    if (!RN) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == TERM) ? '0 : q + ONE;
    end
  end

endmodule

// File: rtl/sync_cnt_decode.sv
// Counter/decode stage feeding the video sync controller: a main line/sample
// counter and a pixel counter, each with one-hot equality decodes taken
// straight off the registered count (no extra pipeline stage).
module sync_cnt_decode
  import sync_cnt_pkg::*;
#(
  parameter int CW   = CW_DEF,
  parameter int PW   = PW_DEF,
  parameter int CMAX = CMAX_DEF,
  parameter int PMAX = PMAX_DEF
) (
  input logic              CK,
  input logic              RN,
  sync_cnt_decode_if.slave bus
);

  // Reject widths that cannot hold the decode points or the terminal values
  if (CW < bits_for(CDEC_MAX) || PW < bits_for(PDEC_MAX)) begin : g_width_chk
    $fatal(1, "sync_cnt_decode: CW/PW too narrow for the largest decode value");
  end
  if (CMAX < 0 || longint'(CMAX) >= (longint'(1) << CW) ||
      PMAX < 0 || longint'(PMAX) >= (longint'(1) << PW)) begin : g_term_chk
    $fatal(1, "sync_cnt_decode: terminal value does not fit the counter width");
  end

  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     pcnt_q;
  logic [N_CDEC-1:0] cdec;
  logic [N_PDEC-1:0] pdec;

  sync_counter #(.W(CW), .TMAX(CMAX)) u_main_cnt (
    .CK  (CK),
    .RN  (RN),
    .clr (bus.cclr),
    .inc (bus.csm),
    .q   (cnt_q)
  );

  sync_counter #(.W(PW), .TMAX(PMAX)) u_pix_cnt (
    .CK  (CK),
    .RN  (RN),
    .clr (bus.pclr),
    .inc (bus.pc),
    .q   (pcnt_q)
  );

  // A decode point beyond the terminal value can never be reached, so it is tied low
  genvar gi;
  for (gi = 0; gi < N_CDEC; gi++) begin : g_cdec
    if (CDEC_VAL[gi] <= CMAX) begin : g_live
      assign cdec[gi] = (cnt_q == CW'(CDEC_VAL[gi]));
    end else begin : g_dead
      assign cdec[gi] = 1'b0;
    end
  end

  for (gi = 0; gi < N_PDEC; gi++) begin : g_pdec
    if (PDEC_VAL[gi] <= PMAX) begin : g_live
      assign pdec[gi] = (pcnt_q == PW'(PDEC_VAL[gi]));
    end else begin : g_dead
      assign pdec[gi] = 1'b0;
    end
  end

  assign bus.cnt_q  = cnt_q;
  assign bus.pcnt_q = pcnt_q;

  assign bus.cnt10  = cdec[0];
  assign bus.cnt13  = cdec[1];
  assign bus.cnt21  = cdec[2];
  assign bus.cnt44  = cdec[3];
  assign bus.cnt45  = cdec[4];
  assign bus.cnt261 = cdec[5];
  assign bus.cnt272 = cdec[6];
  assign bus.cnt283 = cdec[7];
  assign bus.cnt284 = cdec[8];
  assign bus.cnt509 = cdec[9];
  assign bus.cnt511 = cdec[10];
  assign bus.cnt567 = cdec[11];
  assign bus.cnt591 = cdec[12];

  assign bus.pcnt6   = pdec[0];
  assign bus.pcnt12  = pdec[1];
  assign bus.pcnt17  = pdec[2];
  assign bus.pcnt27  = pdec[3];
  assign bus.pcnt241 = pdec[4];

endmodule

// File: tb/tb_sync_cnt_decode.sv
// Self-checking bench for sync_cnt_decode: a table of directed vectors
// followed by hand-written multi-cycle sequences (sweep, wrap, clear
// priority, hold/independence, reset mid-count).
module tb_sync_cnt_decode;

  logic CK;
  logic RN;
  int   checks;
  int   errors;
  int   m_cnt;
  int   m_pcnt;

  sync_cnt_decode_if #(.CW(10), .PW(8)) bus ();

  sync_cnt_decode #(.CW(10), .PW(8), .CMAX(1023), .PMAX(255)) dut (
    .CK  (CK),
    .RN  (RN),
    .bus (bus.slave)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  logic [12:0] cdec_got;
  logic [4:0]  pdec_got;
  assign cdec_got = {bus.cnt591, bus.cnt567, bus.cnt511, bus.cnt509, bus.cnt284,
                     bus.cnt283, bus.cnt272, bus.cnt261, bus.cnt45, bus.cnt44,
                     bus.cnt21, bus.cnt13, bus.cnt10};
  assign pdec_got = {bus.pcnt241, bus.pcnt27, bus.pcnt17, bus.pcnt12, bus.pcnt6};

  function automatic logic [12:0] exp_cdec(input int v);
    int cv [13] = '{10, 13, 21, 44, 45, 261, 272, 283, 284, 509, 511, 567, 591};
    logic [12:0] r;
    r = '0;
    for (int i = 0; i < 13; i++) r[i] = (v == cv[i]);
    return r;
  endfunction

  function automatic logic [4:0] exp_pdec(input int v);
    int pv [5] = '{6, 12, 17, 27, 241};
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r[i] = (v == pv[i]);
    return r;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " cnt_q"}, int'(bus.cnt_q), m_cnt);
    chk({tag, " pcnt_q"}, int'(bus.pcnt_q), m_pcnt);
    chk({tag, " cnt_dec"}, int'(cdec_got), int'(exp_cdec(m_cnt)));
    chk({tag, " pcnt_dec"}, int'(pdec_got), int'(exp_pdec(m_pcnt)));
  endtask

  // Apply one cycle of strobes, advance the reference model, sample #1 after the edge
  task automatic step(input logic rn, input logic c_sm, input logic c_clr,
                      input logic p_c, input logic p_clr);
    RN       = rn;
    bus.csm  = c_sm;
    bus.cclr = c_clr;
    bus.pc   = p_c;
    bus.pclr = p_clr;
    @(posedge CK);
    #1;
    if (!rn) begin
      m_cnt  = 0;
      m_pcnt = 0;
    end else begin
      if (c_clr)     m_cnt = 0;
      else if (c_sm) m_cnt = (m_cnt == 1023) ? 0 : m_cnt + 1;
      if (p_clr)     m_pcnt = 0;
      else if (p_c)  m_pcnt = (m_pcnt == 255) ? 0 : m_pcnt + 1;
    end
  endtask

  typedef struct {
    logic rn, csm, cclr, pc, pclr;
    int   ecnt, epcnt;
  } vec_t;

  vec_t tbl [10];
  int   pulses [13];
  int   ppulses [5];

  initial begin
    checks = 0;
    errors = 0;
    m_cnt  = 0;
    m_pcnt = 0;
    RN       = 1'b0;
    bus.csm  = 1'b0;
    bus.cclr = 1'b0;
    bus.pc   = 1'b0;
    bus.pclr = 1'b0;

    // Hand-computed vectors, continuing from the reset below
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1};   // release: both step to 1
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1};   // main only
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 2};   // pixel only
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 3};   // cclr beats csm
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};   // pclr beats pc
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};   // reset beats increments
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0};   // clears alone
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1};   // hold

    // Reset held 3 cycles with increments requested
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("reset cnt_q", int'(bus.cnt_q), 0);
      chk("reset pcnt_q", int'(bus.pcnt_q), 0);
      chk("reset cnt_dec", int'(cdec_got), 0);
      chk("reset pcnt_dec", int'(pdec_got), 0);
    end

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rn, tbl[i].csm, tbl[i].cclr, tbl[i].pc, tbl[i].pclr);
      m_cnt  = tbl[i].ecnt;
      m_pcnt = tbl[i].epcnt;
      chk($sformatf("vec%0d cnt_q", i), int'(bus.cnt_q), tbl[i].ecnt);
      chk($sformatf("vec%0d pcnt_q", i), int'(bus.pcnt_q), tbl[i].epcnt);
      chk($sformatf("vec%0d cnt_dec", i), int'(cdec_got), int'(exp_cdec(tbl[i].ecnt)));
      chk($sformatf("vec%0d pcnt_dec", i), int'(pdec_got), int'(exp_pdec(tbl[i].epcnt)));
      $display("vec%0d cnt_q=%0d pcnt_q=%0d", i, bus.cnt_q, bus.pcnt_q);
    end

    // Main sweep through 1024 increments: every decode pulses once, then wrap
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 13; k++) pulses[k] = 0;
    for (int i = 1; i <= 1024; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_all($sformatf("sweep%0d", i));
      for (int k = 0; k < 13; k++) if (cdec_got[k]) pulses[k]++;
      if (i == 591)  chk("sweep cnt591", int'(bus.cnt591), 1);
      if (i == 600)  chk("sweep cnt_q@600", int'(bus.cnt_q), 600);
      if (i == 1023) chk("wrap cnt_q@1023", int'(bus.cnt_q), 1023);
      if (i == 1024) chk("wrap cnt_q@1024", int'(bus.cnt_q), 0);
    end
    for (int k = 0; k < 13; k++) chk($sformatf("sweep pulses bit%0d", k), pulses[k], 1);
    $display("main sweep done cnt_q=%0d", bus.cnt_q);

    // Pixel sweep through 256 increments
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) ppulses[k] = 0;
    for (int i = 1; i <= 256; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check_all($sformatf("psweep%0d", i));
      for (int k = 0; k < 5; k++) if (pdec_got[k]) ppulses[k]++;
      if (i == 241) chk("psweep pcnt241", int'(bus.pcnt241), 1);
      if (i == 255) chk("pwrap pcnt_q@255", int'(bus.pcnt_q), 255);
      if (i == 256) chk("pwrap pcnt_q@256", int'(bus.pcnt_q), 0);
    end
    chk("psweep pcnt241 pulses", ppulses[4], 1);
    $display("pixel sweep done pcnt_q=%0d", bus.pcnt_q);

    // Clear priority on both counters
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 283; i++) step(1'b1, 1'b1, 1'b0, i < 17, 1'b0);
    chk("pre-clear cnt283", int'(bus.cnt283), 1);
    chk("pre-clear pcnt17", int'(bus.pcnt17), 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clear cnt_q", int'(bus.cnt_q), 0);
    chk("clear cnt283", int'(bus.cnt283), 0);
    chk("clear pcnt_q", int'(bus.pcnt_q), 0);
    chk("clear pcnt17", int'(bus.pcnt17), 0);
    $display("clear priority cnt_q=%0d pcnt_q=%0d", bus.cnt_q, bus.pcnt_q);

    // Hold main at 44 while the pixel counter runs
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 44; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) ppulses[k] = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("hold%0d cnt_q", i), int'(bus.cnt_q), 44);
      chk($sformatf("hold%0d cnt44", i), int'(bus.cnt44), 1);
      chk($sformatf("hold%0d pcnt_q", i), int'(bus.pcnt_q), i + 1);
      for (int k = 0; k < 5; k++) if (pdec_got[k]) ppulses[k]++;
    end
    for (int k = 0; k < 4; k++) chk($sformatf("hold pcnt pulses bit%0d", k), ppulses[k], 1);
    $display("hold done cnt_q=%0d pcnt_q=%0d", bus.cnt_q, bus.pcnt_q);

    // Reset asserted mid-count
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 509; i++) step(1'b1, 1'b1, 1'b0, i < 27, 1'b0);
    chk("mid cnt509", int'(bus.cnt509), 1);
    chk("mid pcnt27", int'(bus.pcnt27), 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_all("midreset");
    chk("midreset cnt509", int'(bus.cnt509), 0);
    chk("midreset pcnt27", int'(bus.pcnt27), 0);
    $display("mid reset cnt_q=%0d pcnt_q=%0d", bus.cnt_q, bus.pcnt_q);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
